// File: rtl/conv_window_gen_pkg.sv
// Shared definitions for the 3x3 convolution window generator: tap indices,
// controller states and the tap-to-adder-operand map.
package conv_window_gen_pkg;

    localparam int WIDTH_DEF = 9;
    localparam int TAPS      = 9;

    // Tap index k = r*3 + c, with r/c = 0 at top/left.
    localparam int K0 = 0;
    localparam int K1 = 1;
    localparam int K2 = 2;
    localparam int K3 = 3;
    localparam int K4 = 4;
    localparam int K5 = 5;
    localparam int K6 = 6;
    localparam int K7 = 7;
    localparam int K8 = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // Operand slots of the downstream adder tree.
    typedef enum logic [3:0] {
        OP_A0, OP_A1, OP_B0, OP_B1, OP_C0, OP_C1, OP_D0, OP_D1, OP_E
    } operand_e;

    // Which adder-tree operand a given tap feeds.
    function automatic operand_e tap_operand(input int k);
        case (k)
            K0:      return OP_A0;
            K1:      return OP_A1;
            K2:      return OP_B0;
            K3:      return OP_B1;
            K4:      return OP_C0;
            K5:      return OP_C1;
            K6:      return OP_D0;
            K7:      return OP_D1;
            default: return OP_E;
        endcase
    endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of storage: single port, read-before-write. The read is
// combinational so the old contents at addr are visible in the same cycle
// the new pixel is written.
module line_buffer #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 28
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Write the new pixel; the old value has already been read out.
    // NOTE: storage arrays get no reset -- contents are rewritten before use
    // and a reset would turn the RAM into a large bank of flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Builds 3x3 sliding windows from a raster pixel stream using two line
// buffers and a 3x3 register window; emits only fully-interior windows.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 pix_valid,
    input  logic [WIDTH-1:0]     pix_data,
    output logic                 pix_ready,
    output logic                 win_valid,
    input  logic                 win_ready,
    output logic [9*WIDTH-1:0]   win_data,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(2);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);

    state_e           state;
    state_e           state_next;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [WIDTH-1:0] win      [TAPS];
    logic [WIDTH-1:0] win_next [TAPS];
    logic [9*WIDTH-1:0] win_flat;
    logic [WIDTH-1:0] lb0_q;
    logic [WIDTH-1:0] lb1_q;
    logic             accept;
    logic             emit;
    logic             last_pix;

    assign pix_ready = (state == RUN) && (!win_valid || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);
    assign emit      = accept && (row >= ROW_MIN) && (col >= COL_MIN);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // lb0 holds the previous row, lb1 the row before that.
    line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb0 (
        .clk     (clk),
        .we      (accept),
        .addr    (col),
        .wr_data (pix_data),
        .rd_data (lb0_q)
    );

    line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb1 (
        .clk     (clk),
        .we      (accept),
        .addr    (col),
        .wr_data (lb0_q),
        .rd_data (lb1_q)
    );

    // Post-shift window: each row moves left, new right column comes from
    // lb1 / lb0 / the incoming pixel, top to bottom.
    always_comb begin
        win_next[K0] = win[K1];
        win_next[K1] = win[K2];
        win_next[K2] = lb1_q;
        win_next[K3] = win[K4];
        win_next[K4] = win[K5];
        win_next[K5] = lb0_q;
        win_next[K6] = win[K7];
        win_next[K7] = win[K8];
        win_next[K8] = pix_data;
    end

    // Flatten the post-shift window into the output bus layout.
    always_comb begin
        win_flat = '0;
        for (int k = 0; k < TAPS; k++) begin
            win_flat[k*WIDTH +: WIDTH] = win_next[k];
        end
    end

    // Next-state logic for the frame controller.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && last_pix) state_next = DRAIN;
            DRAIN:   if (!win_valid || win_ready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame controller state register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (state == IDLE && start) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // 3x3 register window, shifted on every accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                win[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < TAPS; k++) begin
                win[k] <= win_next[k];
            end
        end
    end

    // Output register: loads interior windows, holds under backpressure,
    // clears only once consumed with nothing new to load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_data  <= '0;
        end else if (emit) begin
            win_valid <= 1'b1;
            win_data  <= win_flat;
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 4x4 frame: basic streaming,
// backpressure, signed pass-through, start while busy, mid-frame reset.
module tb_conv_window_gen;

    localparam int WIDTH = 9;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NWIN  = (IMG_W - 2) * (IMG_H - 2);
    localparam int DW    = 9 * WIDTH;
    localparam int MAX_CYC = 200;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             pix_valid;
    logic [WIDTH-1:0] pix_data;
    logic             pix_ready;
    logic             win_valid;
    logic             win_ready;
    logic [DW-1:0]    win_data;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] pix_mem [NPIX];
    logic [DW-1:0]    wins [$];
    int               done_cnt;
    int               first_win_cyc;
    int               acc10_cyc;

    conv_window_gen #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack9(input int t0, input int t1, input int t2,
                                            input int t3, input int t4, input int t5,
                                            input int t6, input int t7, input int t8);
        logic [DW-1:0] w;
        w = {WIDTH'(t8), WIDTH'(t7), WIDTH'(t6), WIDTH'(t5), WIDTH'(t4),
             WIDTH'(t3), WIDTH'(t2), WIDTH'(t1), WIDTH'(t0)};
        return w;
    endfunction

    // Reference window whose bottom-right pixel is at (r, c).
    function automatic logic [DW-1:0] model_win(input int r, input int c);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w[(i*3+j)*WIDTH +: WIDTH] = pix_mem[(r-2+i)*IMG_W + (c-2+j)];
            end
        end
        return w;
    endfunction

    // Drives one frame from the current negedge. stall_len: cycles of
    // win_ready=0 after the first window; dup_start_at: pixel index at which
    // start is re-pulsed (-1 none); abort_at: return once this pixel is taken.
    task automatic run_frame(input int stall_len, input int dup_start_at, input int abort_at);
        int  p;
        int  cyc;
        int  stall_left;
        bit  stalled;
        int  after_done;
        bit  acc;
        logic [DW-1:0] held;
        p = 0; stall_left = 0; stalled = 0; after_done = -1;
        held = model_win(2, 2);
        wins.delete();
        done_cnt = 0; first_win_cyc = -1; acc10_cyc = -1;
        for (cyc = 0; cyc < MAX_CYC; cyc++) begin
            start     = (cyc == 0) || (dup_start_at >= 0 && p == dup_start_at);
            pix_valid = (p < NPIX);
            pix_data  = (p < NPIX) ? pix_mem[p] : '0;
            win_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                check("stall_pix_ready", DW'(pix_ready), DW'(0));
                check("stall_win_hold", win_data, held);
            end
            if (win_valid && win_ready) wins.push_back(win_data);
            acc = pix_valid && pix_ready;
            @(negedge clk);
            if (acc) begin
                if (p == 10) acc10_cyc = cyc;
                p++;
            end
            if (stall_left > 0) stall_left--;
            if (done) done_cnt++;
            if (win_valid && first_win_cyc < 0) begin
                first_win_cyc = cyc;
                if (stall_len > 0 && !stalled) begin
                    stalled    = 1;
                    stall_left = stall_len;
                end
            end
            if (abort_at >= 0 && p > abort_at) break;
            if (after_done >= 0) after_done++;
            else if (done) after_done = 0;
            if (after_done >= 3) break;
        end
        start = 1'b0; pix_valid = 1'b0; win_ready = 1'b1;
        check("frame_in_budget", DW'(cyc < MAX_CYC), DW'(1));
    endtask

    task automatic check_frame(input string tag);
        int idx;
        logic [DW-1:0] obs;
        check({tag, "_win_count"}, DW'(wins.size()), DW'(NWIN));
        idx = 0;
        for (int r = 2; r < IMG_H; r++) begin
            for (int c = 2; c < IMG_W; c++) begin
                obs = (idx < wins.size()) ? wins[idx] : 'x;
                check({tag, "_win"}, obs, model_win(r, c));
                idx++;
            end
        end
        check({tag, "_done_pulses"}, DW'(done_cnt), DW'(1));
        check({tag, "_idle_after"}, DW'(busy), DW'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pix_ready"}, DW'(pix_ready), DW'(0));
        check({tag, "_win_valid"}, DW'(win_valid), DW'(0));
        check({tag, "_win_data"}, win_data, DW'(0));
        check({tag, "_busy"}, DW'(busy), DW'(0));
        check({tag, "_done"}, DW'(done), DW'(0));
    endtask

    initial begin
        logic [DW-1:0] first_w;
        logic [DW-1:0] last_w;
        rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0; win_ready = 1'b1;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame, pixels 0..15, no backpressure.
        for (int i = 0; i < NPIX; i++) pix_mem[i] = WIDTH'(i);
        run_frame(0, -1, -1);
        check_frame("basic");
        first_w = (wins.size() > 0) ? wins[0] : 'x;
        last_w  = (wins.size() > 3) ? wins[3] : 'x;
        check("basic_first", first_w, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        check("basic_last", last_w, pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));
        check("basic_latency", DW'(first_win_cyc), DW'(acc10_cyc));

        // Backpressure: 5 stalled cycles after the first window.
        run_frame(5, -1, -1);
        check_frame("stall");
        first_w = (wins.size() > 0) ? wins[0] : 'x;
        check("stall_first", first_w, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));

        // Signed extremes pass through bit-exact.
        pix_mem[0]  = 9'h100;
        pix_mem[5]  = 9'h100;
        pix_mem[10] = 9'h0ff;
        pix_mem[15] = 9'h0ff;
        run_frame(0, -1, -1);
        check_frame("signed");
        first_w = (wins.size() > 0) ? wins[0] : 'x;
        last_w  = (wins.size() > 3) ? wins[3] : 'x;
        check("signed_first", first_w, pack9(-256, 1, 2, 4, -256, 6, 8, 9, 255));
        check("signed_last", last_w, pack9(-256, 6, 7, 9, 255, 11, 13, 14, 255));

        // start pulsed mid-frame is ignored.
        for (int i = 0; i < NPIX; i++) pix_mem[i] = WIDTH'(i);
        run_frame(0, 7, -1);
        check_frame("dup_start");

        // Reset after pixel 9, then a fresh frame of 100..115.
        run_frame(0, -1, 9);
        check("abort_busy_before", DW'(busy), DW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NPIX; i++) pix_mem[i] = WIDTH'(100 + i);
        run_frame(0, -1, -1);
        check_frame("fresh");
        first_w = (wins.size() > 0) ? wins[0] : 'x;
        check("fresh_first", first_w, pack9(100, 101, 102, 104, 105, 106, 108, 109, 110));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
